// File: rtl/opsel_pkg.sv
// opsel_pkg: shared state encoding, field defaults and immediate extension for operand_select_pipe.
// The OPSEL_SIGN_EXT_EN macro selects sign- or zero-extension in imm_extend.
package opsel_pkg;
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_EXT = 1'b1} opsel_state_e;
  localparam int OPSEL_WORD_SIZE = 16;
  localparam int OPSEL_REG_SEL_W = 3;
  localparam int OPSEL_IMM_REG_LSB = 8;
  localparam int OPSEL_DST_LSB = 4;
  localparam int OPSEL_SRC_LSB = 0;
  localparam int OPSEL_IMM_W = 8;
  localparam int OPSEL_IMM_SEL_VALUE = 0;
  // Bits at and above imm_w are replaced by the fill bit.
  function automatic logic [63:0] imm_extend(input logic [63:0] word, input int imm_w);
    logic [63:0] m;
    logic fill;
    m = ~(64'hFFFF_FFFF_FFFF_FFFF << imm_w);
`ifdef OPSEL_SIGN_EXT_EN
    fill = |(word & ~(m >> 1) & m);
`else
    fill = 1'b0;
`endif
    return fill ? (word | ~m) : (word & m);
  endfunction
endpackage

// File: rtl/opsel_field_decode.sv
// opsel_field_decode: combinational mapping of an instruction word to operand selects and immediate.
module opsel_field_decode
  import opsel_pkg::*;
#(
  parameter int WORD_SIZE = OPSEL_WORD_SIZE,
  parameter int REG_SEL_W = OPSEL_REG_SEL_W,
  parameter int IMM_REG_LSB = OPSEL_IMM_REG_LSB,
  parameter int DST_LSB = OPSEL_DST_LSB,
  parameter int SRC_LSB = OPSEL_SRC_LSB,
  parameter int IMM_W = OPSEL_IMM_W,
  parameter int IMM_SEL_VALUE = OPSEL_IMM_SEL_VALUE
) (
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 imm_flag,
  output logic [REG_SEL_W-1:0] sel_a,
  output logic [REG_SEL_W:0]   sel_b,
  output logic [WORD_SIZE-1:0] imm_value,
  output logic                 is_imm
);
  always_comb begin
    sel_a = imm_flag ? instruction[IMM_REG_LSB+:REG_SEL_W] : instruction[DST_LSB+:REG_SEL_W];
    sel_b = imm_flag ? (REG_SEL_W+1)'(IMM_SEL_VALUE) : {1'b0, instruction[SRC_LSB+:REG_SEL_W]};
    imm_value = imm_flag ? WORD_SIZE'(imm_extend(64'(instruction), IMM_W)) : '0;
    is_imm = imm_flag;
  end
endmodule

// File: rtl/operand_select_pipe.sv
// operand_select_pipe: registered operand-select decode with valid/ready handshakes and extension-word immediates.
// Build with OPSEL_SIGN_EXT_EN to sign-extend short immediates.
module operand_select_pipe
  import opsel_pkg::*;
#(
  parameter int WORD_SIZE = OPSEL_WORD_SIZE,
  parameter int REG_SEL_W = OPSEL_REG_SEL_W,
  parameter int IMM_REG_LSB = OPSEL_IMM_REG_LSB,
  parameter int DST_LSB = OPSEL_DST_LSB,
  parameter int SRC_LSB = OPSEL_SRC_LSB,
  parameter int IMM_W = OPSEL_IMM_W,
  parameter int IMM_SEL_VALUE = OPSEL_IMM_SEL_VALUE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 imm_flag,
  input  logic                 ext_flag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_SEL_W-1:0] sel_a,
  output logic [REG_SEL_W:0]   sel_b,
  output logic [WORD_SIZE-1:0] imm_value,
  output logic                 is_imm
);
  opsel_state_e state_q, state_d;
  logic out_valid_q, out_valid_d, is_imm_q, is_imm_d, accept, dec_is_imm;
  logic [REG_SEL_W-1:0] sel_a_q, sel_a_d, dec_sel_a;
  logic [REG_SEL_W:0] sel_b_q, sel_b_d, dec_sel_b;
  logic [WORD_SIZE-1:0] imm_q, imm_d, dec_imm;

  opsel_field_decode #(
    .WORD_SIZE(WORD_SIZE), .REG_SEL_W(REG_SEL_W), .IMM_REG_LSB(IMM_REG_LSB),
    .DST_LSB(DST_LSB), .SRC_LSB(SRC_LSB), .IMM_W(IMM_W), .IMM_SEL_VALUE(IMM_SEL_VALUE)
  ) u_dec (
    .instruction(instruction),
    .imm_flag(imm_flag | ext_flag),
    .sel_a(dec_sel_a),
    .sel_b(dec_sel_b),
    .imm_value(dec_imm),
    .is_imm(dec_is_imm)
  );

  always_comb begin
    in_ready = rst_n && !flush && (!out_valid_q || out_ready);
    accept = in_valid && in_ready;
    state_d = state_q;
    out_valid_d = out_valid_q && !out_ready;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    imm_d = imm_q;
    is_imm_d = is_imm_q;
    if (flush) begin
      state_d = S_IDLE;
      out_valid_d = 1'b0;
    end else if (accept && state_q == S_EXT) begin
      imm_d = instruction;
      is_imm_d = 1'b1;
      out_valid_d = 1'b1;
      state_d = S_IDLE;
    end else if (accept) begin
      // A leading extension word only latches selects; the immediate arrives next word.
      sel_a_d = dec_sel_a;
      sel_b_d = dec_sel_b;
      imm_d = ext_flag ? imm_q : dec_imm;
      is_imm_d = dec_is_imm;
      out_valid_d = !ext_flag;
      state_d = ext_flag ? S_EXT : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_valid_q <= 1'b0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      imm_q <= '0;
      is_imm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      imm_q <= imm_d;
      is_imm_q <= is_imm_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;
  assign imm_value = imm_q;
  assign is_imm = is_imm_q;
endmodule

// File: tb/tb_operand_select_pipe.sv
// tb_operand_select_pipe: scoreboard bench for operand_select_pipe.
module tb_operand_select_pipe;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, imm_flag = 0, ext_flag = 0, out_ready = 0;
  logic [15:0] instruction = '0;
  logic in_ready, out_valid, is_imm;
  logic [2:0] sel_a;
  logic [3:0] sel_b;
  logic [15:0] imm_value;
  logic [23:0] q[$];
  logic [23:0] expv;
  int errs = 0, checks = 0, nres = 0, stalls = 0, n0 = 0, s0 = 0;
  bit rnd = 0;

  operand_select_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .imm_flag(imm_flag), .ext_flag(ext_flag),
    .out_valid(out_valid), .out_ready(out_ready), .sel_a(sel_a), .sel_b(sel_b),
    .imm_value(imm_value), .is_imm(is_imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] ext8(input logic [7:0] v);
`ifdef OPSEL_SIGN_EXT_EN
    return {{8{v[7]}}, v};
`else
    return {8'h00, v};
`endif
  endfunction

  function automatic logic [23:0] model(input logic [15:0] w, input bit im);
    return im ? {w[10:8], 4'd0, ext8(w[7:0]), 1'b1} : {w[6:4], 1'b0, w[2:0], 16'h0, 1'b0};
  endfunction

  function automatic logic [23:0] pack();
    return {sel_a, sel_b, imm_value, is_imm};
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [15:0] w, input bit im, input bit ex, input bit push, input logic [23:0] e);
    int n = 0;
    in_valid = 1; instruction = w; imm_flag = im; ext_flag = ex;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n > 0) stalls++;
    if (!in_ready) chk("accept_timeout", 0, 1);
    else if (push) q.push_back(e);
    @(negedge clk);
    in_valid = 0;
  endtask

  always @(negedge clk) if (rnd) out_ready = 1'($urandom_range(0, 1));

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("result", pack(), q.pop_front());
      nres++;
    end
  end

  initial begin
    logic [15:0] w1, w2;
    bit im, ex;
    @(negedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_data", pack(), 0);
    @(negedge clk); rst_n = 1; out_ready = 1;
    send(16'h0523, 0, 0, 1, 24'({3'd2, 4'd3, 16'h0, 1'b0}));
`ifdef OPSEL_SIGN_EXT_EN
    send(16'h0585, 1, 0, 1, 24'({3'd5, 4'd0, 16'hFF85, 1'b1}));
`else
    send(16'h0585, 1, 0, 1, 24'({3'd5, 4'd0, 16'h0085, 1'b1}));
`endif
    send(16'h0300, 0, 1, 0, 0);
    repeat (2) begin #1; chk("ext_no_valid", out_valid, 0); @(negedge clk); end
    send(16'hBEEF, 0, 0, 1, 24'({3'd3, 4'd0, 16'hBEEF, 1'b1}));
    @(negedge clk);
    n0 = nres; s0 = stalls;
    for (int i = 0; i < 4; i++) begin
      w1 = 16'($urandom);
      send(w1, 0, 0, 1, model(w1, 0));
    end
    #3;
    chk("b2b_results", nres - n0, 4);
    chk("b2b_stalls", stalls - s0, 0);
    @(negedge clk);
    out_ready = 0;
    send(16'h0523, 0, 0, 1, model(16'h0523, 0));
    in_valid = 1; instruction = 16'h0585; imm_flag = 1; ext_flag = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", pack(), model(16'h0523, 0));
      @(negedge clk);
    end
    out_ready = 1;
    send(16'h0585, 1, 0, 1, model(16'h0585, 1));
    send(16'h0300, 0, 1, 0, 0);
    flush = 1; in_valid = 1; instruction = 16'hBEEF;
    @(negedge clk);
    flush = 0; in_valid = 0;
    #1; chk("flush_valid", out_valid, 0);
    @(negedge clk);
    send(16'h0523, 0, 0, 1, model(16'h0523, 0));
    send(16'h0300, 1, 1, 0, 0);
    rst_n = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_data", pack(), 0);
    @(negedge clk); rst_n = 1;
    send(16'h0523, 0, 0, 1, model(16'h0523, 0));
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      w1 = 16'($urandom); w2 = 16'($urandom);
      im = 1'($urandom_range(0, 1)); ex = ($urandom_range(0, 3) == 0);
      if (ex) begin
        send(w1, im, 1, 0, 0);
        send(w2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, {w1[10:8], 4'd0, w2, 1'b1});
      end else send(w1, im, 0, 1, model(w1, im));
    end
    rnd = 0;
    @(negedge clk); out_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin @(negedge clk); #3; end
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
